// File: rtl/pp_pkg.sv
// Shared types and constants for the post-process capture sequencer.
package pp_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StFill,
    StHdr0,
    StHdr1,
    StHdr2,
    StHdr3,
    StRdIssue,
    StRdWait,
    StTxHi,
    StTxLo,
    StDone
  } pp_state_e;

  localparam logic [7:0] HDR_SYNC0 = 8'hA5;
  localparam logic [7:0] HDR_SYNC1 = 8'h5A;

endpackage

// File: rtl/pp_word_serializer.sv
// Holds one 16-bit buffer word and presents it as two bytes, high byte first.
module pp_word_serializer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [15:0] i_word,
  input  logic        i_hi_en,
  input  logic        i_lo_en,
  output logic        o_valid,
  output logic [7:0]  o_data
);

  logic [15:0] r_word;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_word <= '0;
    end else if (i_load) begin
      r_word <= i_word;
    end
  end

  always_comb begin
    o_valid = i_hi_en | i_lo_en;
    o_data  = 8'h00;
    if (i_hi_en) begin
      o_data = r_word[15:8];
    end else if (i_lo_en) begin
      o_data = r_word[7:0];
    end
  end

endmodule

// File: rtl/pp_capture_sequencer.sv
// Capture buffer FILL/DRAIN sequencer feeding a byte-wide UART handshake.
// Optional frame header per drain when PP_FRAME_HEADER_EN is defined.
module pp_capture_sequencer
  import pp_pkg::*;
#(
  parameter int unsigned WR_AW  = 7,
  parameter int unsigned RD_AW  = 9,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_sample_valid,
  output logic             o_buf_wr_en,
  output logic [WR_AW-1:0] o_buf_wr_addr,
  output logic             o_buf_rd_en,
  output logic [RD_AW-1:0] o_buf_rd_addr,
  input  logic [15:0]      i_buf_rd_data,
  output logic             o_tx_valid,
  output logic [7:0]       o_tx_data,
  input  logic             i_tx_ready,
  output logic             o_draining,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow
);

  localparam int unsigned     LatW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned     Shift   = RD_AW - WR_AW;
  localparam logic [LatW-1:0] LatLast = LatW'(RD_LAT - 1);
  localparam logic [RD_AW:0]  RdFull  = {1'b1, {RD_AW{1'b0}}};
`ifdef PP_FRAME_HEADER_EN
  localparam pp_state_e DrainEntry = StHdr0;
`else
  localparam pp_state_e DrainEntry = StRdIssue;
`endif

  pp_state_e        r_state, w_state_d;
  logic [WR_AW-1:0] r_wr_addr, w_wr_addr_d;
  logic [WR_AW:0]   r_wr_cnt, w_wr_cnt_d;
  logic [RD_AW-1:0] r_rd_addr, w_rd_addr_d;
  logic [RD_AW:0]   r_rd_max, w_rd_max_d;
  logic [LatW-1:0]  r_lat_cnt, w_lat_cnt_d;
  logic             r_stop, w_stop_d;
  logic             r_overflow, w_overflow_d;

  logic             w_busy, w_stop_now, w_wr_fire;
  logic [WR_AW:0]   w_cnt_next;
  logic [RD_AW:0]   w_rd_next;
  logic             w_load, w_hi_en, w_lo_en;
  logic             w_hdr_valid;
  logic [7:0]       w_hdr_data;
  logic             w_ser_valid;
  logic [7:0]       w_ser_data;
`ifdef PP_FRAME_HEADER_EN
  logic [15:0]      w_rd_max16;
  assign w_rd_max16 = 16'(r_rd_max);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_wr_addr  <= '0;
      r_wr_cnt   <= '0;
      r_rd_addr  <= '0;
      r_rd_max   <= '0;
      r_lat_cnt  <= '0;
      r_stop     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_wr_addr  <= w_wr_addr_d;
      r_wr_cnt   <= w_wr_cnt_d;
      r_rd_addr  <= w_rd_addr_d;
      r_rd_max   <= w_rd_max_d;
      r_lat_cnt  <= w_lat_cnt_d;
      r_stop     <= w_stop_d;
      r_overflow <= w_overflow_d;
    end
  end

  assign w_busy     = (r_state != StIdle) && (r_state != StDone);
  assign w_stop_now = r_stop | i_stop;
  assign w_wr_fire  = (r_state == StFill) & i_sample_valid;
  assign w_cnt_next = r_wr_cnt + (WR_AW + 1)'(w_wr_fire);
  assign w_rd_next  = {1'b0, r_rd_addr} + (RD_AW + 1)'(1);

  always_comb begin
    w_state_d    = r_state;
    w_wr_addr_d  = r_wr_addr;
    w_wr_cnt_d   = r_wr_cnt;
    w_rd_addr_d  = r_rd_addr;
    w_rd_max_d   = r_rd_max;
    w_lat_cnt_d  = r_lat_cnt;
    w_stop_d     = r_stop;
    w_overflow_d = r_overflow;
    w_load       = 1'b0;
    w_hi_en      = 1'b0;
    w_lo_en      = 1'b0;
    w_hdr_valid  = 1'b0;
    w_hdr_data   = 8'h00;
    o_buf_rd_en  = 1'b0;

    if (i_stop && w_busy) begin
      w_stop_d = 1'b1;
    end
    // Samples only land in FILL; anything else after a start is lost data.
    if (i_sample_valid && (r_state != StIdle) && (r_state != StFill)) begin
      w_overflow_d = 1'b1;
    end

    unique case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_state_d    = StFill;
          w_wr_addr_d  = '0;
          w_wr_cnt_d   = '0;
          w_overflow_d = 1'b0;
          w_stop_d     = 1'b0;
        end
      end
      StFill: begin
        if (w_wr_fire) begin
          w_wr_addr_d = r_wr_addr + WR_AW'(1);
          w_wr_cnt_d  = w_cnt_next;
        end
        if (w_wr_fire && (r_wr_addr == {WR_AW{1'b1}})) begin
          w_rd_max_d = RdFull;
          w_state_d  = DrainEntry;
        end else if (w_stop_now) begin
          if (w_cnt_next == '0) begin
            w_state_d = StDone;
            w_stop_d  = 1'b0;
          end else begin
            w_rd_max_d = (RD_AW + 1)'(w_cnt_next) << Shift;
            w_state_d  = DrainEntry;
          end
        end
      end
`ifdef PP_FRAME_HEADER_EN
      StHdr0: begin
        w_hdr_valid = 1'b1;
        w_hdr_data  = HDR_SYNC0;
        if (i_tx_ready) w_state_d = StHdr1;
      end
      StHdr1: begin
        w_hdr_valid = 1'b1;
        w_hdr_data  = HDR_SYNC1;
        if (i_tx_ready) w_state_d = StHdr2;
      end
      StHdr2: begin
        w_hdr_valid = 1'b1;
        w_hdr_data  = w_rd_max16[15:8];
        if (i_tx_ready) w_state_d = StHdr3;
      end
      StHdr3: begin
        w_hdr_valid = 1'b1;
        w_hdr_data  = w_rd_max16[7:0];
        if (i_tx_ready) w_state_d = StRdIssue;
      end
`endif
      StRdIssue: begin
        o_buf_rd_en = 1'b1;
        w_lat_cnt_d = '0;
        w_state_d   = StRdWait;
      end
      StRdWait: begin
        if (r_lat_cnt == LatLast) begin
          w_load    = 1'b1;
          w_state_d = StTxHi;
        end else begin
          w_lat_cnt_d = r_lat_cnt + LatW'(1);
        end
      end
      StTxHi: begin
        w_hi_en = 1'b1;
        if (i_tx_ready) w_state_d = StTxLo;
      end
      StTxLo: begin
        w_lo_en = 1'b1;
        if (i_tx_ready) begin
          if (w_rd_next == r_rd_max) begin
            w_rd_addr_d = '0;
            if (w_stop_now) begin
              w_state_d = StDone;
              w_stop_d  = 1'b0;
            end else begin
              w_state_d   = StFill;
              w_wr_addr_d = '0;
              w_wr_cnt_d  = '0;
            end
          end else begin
            w_rd_addr_d = w_rd_next[RD_AW-1:0];
            w_state_d   = StRdIssue;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  pp_word_serializer u_ser (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_word  (i_buf_rd_data),
    .i_hi_en (w_hi_en),
    .i_lo_en (w_lo_en),
    .o_valid (w_ser_valid),
    .o_data  (w_ser_data)
  );

  assign o_buf_wr_en   = w_wr_fire;
  assign o_buf_wr_addr = r_wr_addr;
  assign o_buf_rd_addr = r_rd_addr;
  assign o_tx_valid    = w_hdr_valid | w_ser_valid;
  assign o_tx_data     = w_hdr_valid ? w_hdr_data : w_ser_data;
  assign o_draining    = r_state inside {StHdr0, StHdr1, StHdr2, StHdr3,
                                         StRdIssue, StRdWait, StTxHi, StTxLo};
  assign o_busy        = w_busy;
  assign o_done        = (r_state == StDone);
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_pp_capture_sequencer.sv
// Directed bench for pp_capture_sequencer: per-cycle vector table plus drain sequences
// checked against a buffer model and an expected byte stream.
module tb_pp_capture_sequencer;

`ifdef PP_FRAME_HEADER_EN
  localparam int HdrN = 4;
`else
  localparam int HdrN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, sample_valid = 1'b0, tx_ready = 1'b0;
  logic        buf_wr_en, buf_rd_en, tx_valid, draining, busy, done, overflow;
  logic [6:0]  buf_wr_addr;
  logic [8:0]  buf_rd_addr;
  logic [15:0] buf_rd_data = 16'h0000;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  pp_capture_sequencer dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_stop         (stop),
    .i_sample_valid (sample_valid),
    .o_buf_wr_en    (buf_wr_en),
    .o_buf_wr_addr  (buf_wr_addr),
    .o_buf_rd_en    (buf_rd_en),
    .o_buf_rd_addr  (buf_rd_addr),
    .i_buf_rd_data  (buf_rd_data),
    .o_tx_valid     (tx_valid),
    .o_tx_data      (tx_data),
    .i_tx_ready     (tx_ready),
    .o_draining     (draining),
    .o_busy         (busy),
    .o_done         (done),
    .o_overflow     (overflow)
  );

  function automatic logic [15:0] lane(input int n, input int j);
    return {8'(n) ^ 8'hA5, 8'(16 * j + 3)};
  endfunction

  function automatic logic [63:0] sample_word(input int n);
    return {lane(n, 3), lane(n, 2), lane(n, 1), lane(n, 0)};
  endfunction

  // Capture buffer: 64-bit write port, 16-bit read port, one cycle read latency.
  logic [63:0] mem [128];
  int          cap_cnt = 0;
  int          cap_base = 0;
  always @(posedge clk) begin
    if (buf_wr_en) begin
      mem[buf_wr_addr] <= sample_word(cap_cnt - cap_base);
      cap_cnt <= cap_cnt + 1;
    end
    if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr[8:2]][{buf_rd_addr[1:0], 4'b0000} +: 16];
  end

  int         n_cmp = 0, n_bad = 0;
  int         wr_exp, rd_exp, rd_en_cnt, tx_cnt, budget;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] pk(input logic we, input logic [6:0] wa, input logic re,
                                     input logic [8:0] ra, input logic tv, input logic [7:0] td,
                                     input logic dr, input logic bs, input logic dn,
                                     input logic ov);
    return {1'b0, we, wa, re, ra, tv, td, dr, bs, dn, ov};
  endfunction

  function automatic logic [31:0] outs();
    return pk(buf_wr_en, buf_wr_addr, buf_rd_en, buf_rd_addr, tx_valid, tx_data,
              draining, busy, done, overflow);
  endfunction

  // One clock: drive at negedge, observe 1 ns later while inputs are stable.
  task automatic step(input logic r, input logic st, input logic sp, input logic sv,
                      input logic rdy);
    @(negedge clk);
    rst_n = r; start = st; stop = sp; sample_valid = sv; tx_ready = rdy;
    #1;
    if (prev_stall) cmp("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
    prev_stall = tx_valid && !tx_ready && rst_n;
    prev_data  = tx_data;
    if (rst_n) begin
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (tx_valid) tx_cnt++;
      if (buf_wr_en) begin
        cmp("wr_addr", 32'(buf_wr_addr), 32'(wr_exp));
        wr_exp++;
      end
      if (buf_rd_en) begin
        cmp("rd_addr", 32'(buf_rd_addr), 32'(rd_exp));
        rd_exp++;
        rd_en_cnt++;
      end
    end
  endtask

  task automatic build_exp(input int nwords, input logic [15:0] rdmax);
    logic [15:0] w;
    exp_q.delete();
`ifdef PP_FRAME_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(rdmax[15:8]);
    exp_q.push_back(rdmax[7:0]);
`endif
    for (int a = 0; a < nwords; a++) begin
      w = lane(a >> 2, a & 3);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
    if (rdmax == 16'hFFFF) $display("note: unexpected rd_max argument");
  endtask

  task automatic check_bytes(input string name);
    cmp({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      cmp(name, 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic new_capture();
    got_q.delete();
    cap_base  = cap_cnt;
    wr_exp    = 0;
    rd_exp    = 0;
    rd_en_cnt = 0;
    tx_cnt    = 0;
  endtask

  typedef struct {
    logic        r, st, sp, sv, rdy;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic st, input logic sp, input logic sv,
                     input logic rdy, input logic [31:0] e);
    vec_t v;
    v.r = r; v.st = st; v.sp = sp; v.sv = sv; v.rdy = rdy; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    new_capture();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("reset_outs", outs(), 32'd0);

    // Short capture: 3 samples, stop with the third, then start of the drain.
    add(1, 0, 0, 0, 0, pk(0, 7'd0, 0, 9'd0, 0, 8'h00, 0, 0, 0, 0));
    add(1, 1, 0, 0, 0, pk(0, 7'd0, 0, 9'd0, 0, 8'h00, 0, 0, 0, 0));
    add(1, 0, 0, 1, 0, pk(1, 7'd0, 0, 9'd0, 0, 8'h00, 0, 1, 0, 0));
    add(1, 0, 0, 1, 0, pk(1, 7'd1, 0, 9'd0, 0, 8'h00, 0, 1, 0, 0));
    add(1, 0, 0, 0, 0, pk(0, 7'd2, 0, 9'd0, 0, 8'h00, 0, 1, 0, 0));
    add(1, 0, 1, 1, 0, pk(1, 7'd2, 0, 9'd0, 0, 8'h00, 0, 1, 0, 0));
`ifdef PP_FRAME_HEADER_EN
    add(1, 0, 0, 0, 1, pk(0, 7'd3, 0, 9'd0, 1, 8'hA5, 1, 1, 0, 0));
    add(1, 0, 0, 0, 1, pk(0, 7'd3, 0, 9'd0, 1, 8'h5A, 1, 1, 0, 0));
    add(1, 0, 0, 0, 1, pk(0, 7'd3, 0, 9'd0, 1, 8'h00, 1, 1, 0, 0));
    add(1, 0, 0, 0, 1, pk(0, 7'd3, 0, 9'd0, 1, 8'h0C, 1, 1, 0, 0));
`endif
    add(1, 0, 0, 0, 0, pk(0, 7'd3, 1, 9'd0, 0, 8'h00, 1, 1, 0, 0));
    add(1, 0, 0, 0, 0, pk(0, 7'd3, 0, 9'd0, 0, 8'h00, 1, 1, 0, 0));
    add(1, 0, 0, 0, 0, pk(0, 7'd3, 0, 9'd0, 1, 8'hA5, 1, 1, 0, 0));
    add(1, 0, 0, 0, 1, pk(0, 7'd3, 0, 9'd0, 1, 8'hA5, 1, 1, 0, 0));
    add(1, 0, 0, 0, 0, pk(0, 7'd3, 0, 9'd0, 1, 8'h03, 1, 1, 0, 0));
    add(1, 0, 0, 0, 1, pk(0, 7'd3, 0, 9'd0, 1, 8'h03, 1, 1, 0, 0));
    add(1, 0, 0, 1, 0, pk(0, 7'd3, 1, 9'd1, 0, 8'h00, 1, 1, 0, 0));
    add(1, 0, 0, 0, 0, pk(0, 7'd3, 0, 9'd1, 0, 8'h00, 1, 1, 0, 1));
    add(1, 0, 0, 0, 1, pk(0, 7'd3, 0, 9'd1, 1, 8'hA5, 1, 1, 0, 1));
    add(1, 0, 0, 0, 1, pk(0, 7'd3, 0, 9'd1, 1, 8'h13, 1, 1, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].st, tbl[i].sp, tbl[i].sv, tbl[i].rdy);
      cmp($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    budget = 0;
    while (!done && budget < 300) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      budget++;
    end
    cmp("short_timeout", 32'(budget < 300), 32'd1);
    cmp("short_done", outs(), pk(0, 7'd3, 0, 9'd0, 0, 8'h00, 0, 0, 1, 1));
    build_exp(12, 16'd12);
    check_bytes("short_bytes");

    // Start clears overflow; an immediate stop with nothing captured goes straight to DONE.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    new_capture();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cmp("start_clears", outs(), pk(0, 7'd0, 0, 9'd0, 0, 8'h00, 0, 1, 0, 0));
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("empty_done", outs(), pk(0, 7'd0, 0, 9'd0, 0, 8'h00, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("empty_no_rd", 32'(rd_en_cnt), 32'd0);
    cmp("empty_no_tx", 32'(tx_cnt), 32'd0);

    // Full buffer: 128 writes, 512 reads, then back to FILL.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    new_capture();
    for (int i = 0; i < 128; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    budget = 0;
    while (got_q.size() < 1024 + HdrN && budget < 3000) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      budget++;
    end
    cmp("full_timeout", 32'(budget < 3000), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("full_wr_count", 32'(wr_exp), 32'd128);
    cmp("full_rd_count", 32'(rd_exp), 32'd512);
    cmp("full_refill", outs(), pk(0, 7'd0, 0, 9'd0, 0, 8'h00, 0, 1, 0, 0));
    build_exp(512, 16'd512);
    check_bytes("full_bytes");

    // Backpressure: already in FILL, 5 samples, stop with the last, ready about 30%.
    new_capture();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    budget = 0;
    while (!done && budget < 2000) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 9) < 3));
      budget++;
    end
    cmp("bp_timeout", 32'(budget < 2000), 32'd1);
    build_exp(20, 16'd20);
    check_bytes("bp_bytes");

    // Reset while holding the low byte, then a fresh 2-sample capture.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    new_capture();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    budget = 0;
    while (got_q.size() < HdrN + 1 && budget < 100) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      budget++;
    end
    cmp("abort_timeout", 32'(budget < 100), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("abort_lo_byte", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h03});
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("abort_reset", outs(), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    new_capture();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    budget = 0;
    while (!done && budget < 200) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      budget++;
    end
    cmp("post_reset_timeout", 32'(budget < 200), 32'd1);
    build_exp(8, 16'd8);
    check_bytes("post_reset_bytes");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
